// File: rtl/heartbeat_analyzer.sv
// heartbeat_analyzer
//   Rhythm-analysis stage feeding the AED control FSM. Measures the R-R
//   interval between accepted beat edges and reports whether a heartbeat is
//   present (H) and whether the rhythm is regular (R).
//
// Ports
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-low reset
//   beat         in   1  beat detect level from the ECG front end (sync to clk)
//   H            out  1  heartbeat present (registered)
//   R            out  1  regular rhythm, never high while H is low (registered)
//   interval     out  W  last accepted R-R interval in cycles; held through LOST
//   int_valid    out  1  one-cycle strobe when interval updates
//   o_dbg_state  out  2  current FSM state (LOST=0, ACQUIRE=1, TRACK=2)
//
// Handshake: there is no back-pressure. int_valid is a pure strobe; a
// consumer must sample interval in the same cycle int_valid is high.
module heartbeat_analyzer #(
  parameter int TIMEOUT = 200,
  parameter int MIN_INT = 20,
  parameter int TOL     = 10,
  parameter int NREG    = 3,
  localparam int W      = $clog2(TIMEOUT + 2)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beat,
  output logic         H,
  output logic         R,
  output logic [W-1:0] interval,
  output logic         int_valid,
  output logic [1:0]   o_dbg_state
);

  localparam int MW = $clog2(NREG + 1);

  localparam logic [W-1:0]  C_SAT  = W'(TIMEOUT + 1);
  localparam logic [W-1:0]  C_MAX  = W'(TIMEOUT);
  localparam logic [W-1:0]  C_MIN  = W'(MIN_INT);
  localparam logic [W-1:0]  C_TOL  = W'(TOL);
  localparam logic [W-1:0]  C_ONE  = W'(1);
  localparam logic [MW-1:0] C_NREG = MW'(NREG);

  typedef enum logic [1:0] {
    ST_LOST    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } state_t;

  state_t        r_state, w_state_next;
  logic          r_beat_q;
  logic [W-1:0]  r_cnt, w_cnt_next;
  logic [W-1:0]  r_prev, w_prev_next;
  logic [MW-1:0] r_match, w_match_next;
  logic [W-1:0]  r_interval, w_interval_next;
  logic          r_int_valid, w_int_valid_next;
  logic          r_h, r_r;

  logic          w_edge;
  logic          w_sat;
  logic          w_in_window;
  logic [W-1:0]  w_diff;
  logic          w_regular;

  assign w_edge      = beat & ~r_beat_q;
  assign w_sat       = (r_cnt == C_SAT);
  assign w_in_window = (r_cnt >= C_MIN) && (r_cnt <= C_MAX);
  // Unsigned distance without wrap: subtract the smaller from the larger.
  assign w_diff      = (r_cnt >= r_prev) ? (r_cnt - r_prev) : (r_prev - r_cnt);
  assign w_regular   = (w_diff <= C_TOL);

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = w_sat ? r_cnt : (r_cnt + C_ONE);
    w_prev_next      = r_prev;
    w_match_next     = r_match;
    w_interval_next  = r_interval;
    w_int_valid_next = 1'b0;

    case (r_state)
      ST_LOST: begin
        if (w_edge) begin
          w_state_next = ST_ACQUIRE;
          w_cnt_next   = C_ONE;
          w_match_next = '0;
        end
      end

      ST_ACQUIRE, ST_TRACK: begin
        if (w_edge && w_in_window) begin
          w_state_next     = ST_TRACK;
          w_cnt_next       = C_ONE;
          w_interval_next  = r_cnt;
          w_prev_next      = r_cnt;
          w_int_valid_next = 1'b1;
          if (r_state == ST_ACQUIRE || !w_regular) begin
            w_match_next = '0;
          end else if (r_match != C_NREG) begin
            w_match_next = r_match + MW'(1);
          end
        end else if (w_sat) begin
          // Timed out. An edge landing on this same cycle is judged as if we
          // were already LOST, so it immediately starts a fresh acquisition.
          w_match_next = '0;
          if (w_edge) begin
            w_state_next = ST_ACQUIRE;
            w_cnt_next   = C_ONE;
          end else begin
            w_state_next = ST_LOST;
          end
        end
      end

      default: begin
        w_state_next = ST_LOST;
        w_match_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_LOST;
      r_beat_q    <= 1'b0;
      r_cnt       <= '0;
      r_prev      <= '0;
      r_match     <= '0;
      r_interval  <= '0;
      r_int_valid <= 1'b0;
      r_h         <= 1'b0;
      r_r         <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_beat_q    <= beat;
      r_cnt       <= w_cnt_next;
      r_prev      <= w_prev_next;
      r_match     <= w_match_next;
      r_interval  <= w_interval_next;
      r_int_valid <= w_int_valid_next;
      r_h         <= (w_state_next == ST_TRACK);
      r_r         <= (w_state_next == ST_TRACK) && (w_match_next == C_NREG);
    end
  end

  assign H           = r_h;
  assign R           = r_r;
  assign interval    = r_interval;
  assign int_valid   = r_int_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_heartbeat_analyzer.sv
// Bench for heartbeat_analyzer: directed scenarios followed by randomized beat
// trains, checked every cycle against a timestamp-based reference model and an
// interval scoreboard.
module tb_heartbeat_analyzer;

  localparam int TIMEOUT = 20;
  localparam int MIN_INT = 4;
  localparam int TOL     = 2;
  localparam int NREG    = 3;
  localparam int W       = $clog2(TIMEOUT + 2);

  localparam int M_LOST  = 0;
  localparam int M_ACQ   = 1;
  localparam int M_TRACK = 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         beat;
  logic         H, R, int_valid;
  logic [W-1:0] interval;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  heartbeat_analyzer #(
    .TIMEOUT (TIMEOUT),
    .MIN_INT (MIN_INT),
    .TOL     (TOL),
    .NREG    (NREG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .beat        (beat),
    .H           (H),
    .R           (R),
    .interval    (interval),
    .int_valid   (int_valid),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard / counters ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Works on absolute cycle timestamps: the interval is simply "now minus the
  // time of the last accepted beat", and the regular-run length is a count.
  int   m_mode;
  int   m_now;
  int   m_last;
  int   m_prev_ivl;
  int   m_run;
  int   m_ivl;
  logic m_iv;
  logic m_beat_prev;

  task automatic model_reset();
    m_mode      = M_LOST;
    m_last      = m_now;
    m_prev_ivl  = 0;
    m_run       = 0;
    m_ivl       = 0;
    m_iv        = 1'b0;
    m_beat_prev = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic b);
    logic e;
    int   el;
    int   d;
    m_now++;
    if (!reset) begin
      model_reset();
      return;
    end
    e           = b && !m_beat_prev;
    m_beat_prev = b;
    m_iv        = 1'b0;
    el          = m_now - m_last;
    if (m_mode == M_LOST) begin
      if (e) begin
        m_mode = M_ACQ;
        m_last = m_now;
      end
    end else if (e && el >= MIN_INT && el <= TIMEOUT) begin
      if (m_mode == M_TRACK) begin
        d = el - m_prev_ivl;
        if (d < 0) d = -d;
        m_run = (d <= TOL) ? ((m_run + 1 > NREG) ? NREG : m_run + 1) : 0;
      end else begin
        m_run = 0;
      end
      m_mode     = M_TRACK;
      m_ivl      = el;
      m_prev_ivl = el;
      m_iv       = 1'b1;
      m_last     = m_now;
      exp_q.push_back(W'(el));
    end else if (el > TIMEOUT) begin
      m_run = 0;
      if (e) begin
        m_mode = M_ACQ;
        m_last = m_now;
      end else begin
        m_mode = M_LOST;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic compare_all();
    logic [W-1:0] e_ivl;
    check("H", 32'(H), 32'(m_mode == M_TRACK));
    check("R", 32'(R), 32'((m_mode == M_TRACK) && (m_run == NREG)));
    check("interval", 32'(interval), 32'(m_ivl));
    check("int_valid", 32'(int_valid), 32'(m_iv));
    if (int_valid === 1'b1) begin
      check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e_ivl = exp_q.pop_front();
        check("sb_interval", 32'(interval), 32'(e_ivl));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic b, input logic rn = 1'b1);
    @(negedge clk);
    beat  = b;
    reset = rn;
    @(posedge clk);
    model_step(b);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int gap;
    int hi;

    reset = 1'b0;
    beat  = 1'b0;
    m_now = 0;
    model_reset();

    // 1: reset held while beat toggles, then quiet after release
    for (int i = 0; i < 8; i++) cycle(logic'(i % 2), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    check("t1_h_idle", 32'(H), 32'd0);
    check("t1_ivl_idle", 32'(interval), 32'd0);

    // 2: five beats 10 cycles apart
    cycle(1'b1); idle(9);
    cycle(1'b1);
    check("t2_h_2nd", 32'(H), 32'd1);
    check("t2_ivl_2nd", 32'(interval), 32'd10);
    check("t2_iv_2nd", 32'(int_valid), 32'd1);
    idle(9);
    cycle(1'b1); idle(9);
    cycle(1'b1);
    check("t2_r_4th", 32'(R), 32'd0);
    idle(9);
    cycle(1'b1);
    check("t2_r_5th", 32'(R), 32'd1);
    idle(9);

    // 3: one more 10, then a 15 breaks regularity; three 15s restore it
    cycle(1'b1); idle(14);
    cycle(1'b1);
    check("t3_r_break", 32'(R), 32'd0);
    check("t3_h_stay", 32'(H), 32'd1);
    check("t3_ivl_15", 32'(interval), 32'd15);
    idle(14);
    cycle(1'b1); idle(14);
    cycle(1'b1);
    check("t3_r_still0", 32'(R), 32'd0);
    idle(14);
    cycle(1'b1);
    check("t3_r_back", 32'(R), 32'd1);

    // 4: beats stop; drop exactly 21 cycles after the last beat
    idle(20);
    check("t4_h_at20", 32'(H), 32'd1);
    check("t4_r_at20", 32'(R), 32'd1);
    cycle(1'b0);
    check("t4_h_at21", 32'(H), 32'd0);
    check("t4_r_at21", 32'(R), 32'd0);
    idle(5);
    cycle(1'b1);
    check("t4_acq_h", 32'(H), 32'd0);
    check("t4_acq_iv", 32'(int_valid), 32'd0);
    check("t4_ivl_held", 32'(interval), 32'd15);
    idle(9);
    cycle(1'b1);
    check("t4_track_ivl", 32'(interval), 32'd10);

    // 5: noise edge 2 cycles after a beat, a held-high beat, an edge at cnt==20
    idle(1);
    cycle(1'b1);
    check("t5_noise_iv", 32'(int_valid), 32'd0);
    idle(7);
    cycle(1'b1);
    check("t5_noise_ivl", 32'(interval), 32'd10);
    idle(9);
    for (int i = 0; i < 6; i++) cycle(1'b1);
    idle(4);
    cycle(1'b1);
    check("t5_held_ivl", 32'(interval), 32'd10);
    check("t5_held_iv", 32'(int_valid), 32'd1);
    idle(19);
    cycle(1'b1);
    check("t5_ivl_20", 32'(interval), 32'd20);
    check("t5_h_20", 32'(H), 32'd1);

    // 6: build R=1 then pulse reset between clock edges
    for (int k = 0; k < 4; k++) begin
      idle(9);
      cycle(1'b1);
    end
    check("t6_r_before", 32'(R), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_h_async", 32'(H), 32'd0);
    check("t6_r_async", 32'(R), 32'd0);
    check("t6_ivl_async", 32'(interval), 32'd0);
    model_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b1);
    check("t6_restart_h", 32'(H), 32'd0);
    idle(9);
    cycle(1'b1);
    check("t6_restart_track", 32'(H), 32'd1);
    check("t6_restart_ivl", 32'(interval), 32'd10);

    // randomized beat trains: mostly near-regular, with occasional wild gaps
    base = $urandom_range(6, 14);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) gap = $urandom_range(2, 24);
      else                           gap = base + $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) base = $urandom_range(6, 14);
      hi = (gap > 4) ? $urandom_range(1, 3) : 1;
      for (int i = 0; i < hi; i++) cycle(1'b1);
      for (int i = hi; i < gap; i++) cycle(1'b0);
    end
    idle(25);

    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
